// File: rtl/spi_slave.sv
// -----------------------------------------------------------------------------
// spi_slave
//   SPI slave. It oversamples the asynchronous SPI pins in the clk domain and
//   supports all four CPOL/CPHA modes. Received data is shifted in MSB-first
//   and handed over through a valid/ack pair. A single-entry transmit buffer
//   supplies the next outgoing byte.
//
// Ports
//   clk, rst_n   system clock; synchronous active-low reset
//   spcon[2:0]   {cpol, cpha, enable}; must be stable while ssn is low
//   sck/ssn/mosi asynchronous SPI pins from the master
//   miso/miso_oe slave data out and its enable (enable is 1 while selected)
//   tx_data/tx_load/tx_ready  transmit buffer write port and empty flag
//   rx_data/rx_valid/rx_ack/rx_overrun  receive handshake and sticky overrun
//   busy         high while a transfer is in progress
// -----------------------------------------------------------------------------
module spi_slave #(
    parameter int unsigned SYNC_STAGES = 2,
    parameter logic [7:0]  TX_FILL     = 8'hFF
) (
    input  logic       clk,
    input  logic       rst_n,
    input  logic [7:0] spcon,
    input  logic       sck,
    input  logic       ssn,
    input  logic       mosi,
    output logic       miso,
    output logic       miso_oe,
    input  logic [7:0] tx_data,
    input  logic       tx_load,
    output logic       tx_ready,
    output logic [7:0] rx_data,
    output logic       rx_valid,
    input  logic       rx_ack,
    output logic       rx_overrun,
    output logic       busy
);

    localparam logic [0:0] ST_IDLE   = 1'b0;
    localparam logic [0:0] ST_ACTIVE = 1'b1;

    logic                   en, cpha, cpol;
    logic                   spcon_unused;
    logic [SYNC_STAGES-1:0] sck_sync, ssn_sync, mosi_sync;
    logic                   sck_s, ssn_s, mosi_s;
    logic                   sck_prev, ssn_prev;

    logic [0:0] state, state_n;
    logic [2:0] cnt, cnt_n;
    logic [7:0] rx_sr, rx_sr_n;
    logic [7:0] tx_sr, tx_sr_n;
    logic [7:0] tx_buf, tx_buf_n;
    logic       tx_ready_n;
    logic [7:0] rx_data_n;
    logic       rx_valid_n, rx_overrun_n;
    logic       miso_n, miso_oe_n, busy_n;

    logic sck_edge, lead_edge, trail_edge, sample_edge, shift_edge;
    logic load_pt, byte_done;

    assign en           = spcon[0];
    assign cpha         = spcon[1];
    assign cpol         = spcon[2];
    assign spcon_unused = ^spcon[7:3];

    assign sck_s  = sck_sync[SYNC_STAGES-1];
    assign ssn_s  = ssn_sync[SYNC_STAGES-1];
    assign mosi_s = mosi_sync[SYNC_STAGES-1];

    // Leading edge leaves the idle (cpol) level, trailing edge returns to it.
    assign sck_edge    = sck_s ^ sck_prev;
    assign lead_edge   = sck_edge & (sck_prev == cpol);
    assign trail_edge  = sck_edge & (sck_s == cpol);
    assign sample_edge = cpha ? trail_edge : lead_edge;
    assign shift_edge  = cpha ? lead_edge  : trail_edge;

    // Next-state and datapath decisions.
    always_comb begin
        state_n      = state;
        cnt_n        = cnt;
        rx_sr_n      = rx_sr;
        tx_sr_n      = tx_sr;
        tx_buf_n     = tx_buf;
        tx_ready_n   = tx_ready;
        rx_data_n    = rx_data;
        rx_valid_n   = rx_valid;
        rx_overrun_n = rx_overrun;
        load_pt      = 1'b0;
        byte_done    = 1'b0;

        case (state)
            ST_IDLE: begin
                if (ssn_prev && !ssn_s && en) begin
                    state_n = ST_ACTIVE;
                    cnt_n   = 3'd0;
                    // cpha=0 must present bit 7 before the first sck edge.
                    load_pt = !cpha;
                end
            end
            ST_ACTIVE: begin
                if (ssn_s || !en) begin
                    // Abort or normal end: drop any partial byte.
                    state_n = ST_IDLE;
                    cnt_n   = 3'd0;
                    rx_sr_n = 8'd0;
                end else begin
                    if (sample_edge) begin
                        rx_sr_n   = {rx_sr[6:0], mosi_s};
                        cnt_n     = 3'(cnt + 3'd1);
                        byte_done = (cnt == 3'd7);
                    end
                    if (shift_edge) begin
                        if (cnt == 3'd0) begin
                            load_pt = 1'b1;
                        end else begin
                            tx_sr_n = {tx_sr[6:0], 1'b0};
                        end
                    end
                end
            end
            default: state_n = ST_IDLE;
        endcase

        // Load point takes the buffered byte, or the filler when empty.
        if (load_pt) begin
            if (!tx_ready) begin
                tx_sr_n    = tx_buf;
                tx_ready_n = 1'b1;
            end else begin
                tx_sr_n = TX_FILL;
            end
        end

        // A write is accepted only into an empty buffer.
        if (tx_load && tx_ready) begin
            tx_buf_n   = tx_data;
            tx_ready_n = 1'b0;
        end

        if (byte_done) begin
            rx_data_n    = {rx_sr[6:0], mosi_s};
            rx_valid_n   = 1'b1;
            rx_overrun_n = rx_ack ? 1'b0 : (rx_overrun | rx_valid);
        end else if (rx_ack) begin
            rx_valid_n   = 1'b0;
            rx_overrun_n = 1'b0;
        end

        miso_oe_n = (state_n == ST_ACTIVE);
        busy_n    = (state_n == ST_ACTIVE);
        miso_n    = (state_n == ST_ACTIVE) ? tx_sr_n[7] : 1'b0;
    end

    // State, synchronizers and registered outputs.
    always_ff @(posedge clk) begin
        if (!rst_n) begin
            sck_sync   <= {SYNC_STAGES{spcon[2]}};
            ssn_sync   <= {SYNC_STAGES{1'b1}};
            mosi_sync  <= {SYNC_STAGES{1'b0}};
            sck_prev   <= spcon[2];
            ssn_prev   <= 1'b1;
            state      <= ST_IDLE;
            cnt        <= 3'd0;
            rx_sr      <= 8'd0;
            tx_sr      <= 8'd0;
            tx_buf     <= 8'd0;
            tx_ready   <= 1'b1;
            rx_data    <= 8'd0;
            rx_valid   <= 1'b0;
            rx_overrun <= 1'b0;
            miso       <= 1'b0;
            miso_oe    <= 1'b0;
            busy       <= 1'b0;
        end else begin
            sck_sync   <= {sck_sync[SYNC_STAGES-2:0], sck};
            ssn_sync   <= {ssn_sync[SYNC_STAGES-2:0], ssn};
            mosi_sync  <= {mosi_sync[SYNC_STAGES-2:0], mosi};
            sck_prev   <= sck_s;
            ssn_prev   <= ssn_s;
            state      <= state_n;
            cnt        <= cnt_n;
            rx_sr      <= rx_sr_n;
            tx_sr      <= tx_sr_n;
            tx_buf     <= tx_buf_n;
            tx_ready   <= tx_ready_n;
            rx_data    <= rx_data_n;
            rx_valid   <= rx_valid_n;
            rx_overrun <= rx_overrun_n;
            miso       <= miso_n;
            miso_oe    <= miso_oe_n;
            busy       <= busy_n;
        end
    end

endmodule
